usb_rst_sequencer: RTL
======================

// Module: usb_rst_sequencer
// PURPOSE
//  Avalon-MM slave that sequences the USB host-controller reset line instead of raw CPU bit-banging.
//  One START write produces an exact-width reset pulse, then a settle wait, then a sticky DONE flag and optional IRQ.
//  Sits in finalProject_soc beside the USB SPI/PIO peripherals; out_port drives the USB chip reset pin.
// PARAMETERS
//  CNT_W          24     width of pulse/settle counters and their registers
//  ASSERT_LEVEL   1'b0   out_port level that holds the USB chip in reset (0 = active-low pin)
//  PULSE_DEFAULT  500    reset value of PULSE_CYCLES (10 us at 50 MHz)
//  SETTLE_DEFAULT 50000  reset value of SETTLE_CYCLES (1 ms at 50 MHz)
//  AUTO_START     1      1 = start one sequence automatically when reset is released
// PORTS
//  clk         in   1      system clock
//  reset       in   1      synchronous, active-high reset
//  address     in   2      register word offset
//  chipselect  in   1      slave select
//  write_n     in   1      active-low write strobe; a write is chipselect & ~write_n
//  writedata   in   32     write data
//  readdata    out  32     combinational read data for the current address (zero wait states)
//  out_port    out  1      USB chip reset pin
//  irq         out  1      level interrupt = done & irq_en
// BEHAVIOUR
//  Register map (unused bits read 0):
//   0 CTRL/STAT  W: b0 START, b1 ABORT, b2 IRQ_EN (stored).
//                R: b0 busy, b1 done, b2 irq_en, b3 aborted, b5:4 state.
//   1 PULSE_CYCLES   R/W [CNT_W-1:0]
//   2 SETTLE_CYCLES  R/W [CNT_W-1:0]
//   3 W: any write clears done and aborted. R: remaining count of the active phase.
//  FSM states: IDLE(0), PULSE(1), SETTLE(2). The encoding is visible in STAT[5:4].
//   IDLE -> PULSE on START: load counter with max(PULSE_CYCLES,1)-1; clear done and aborted.
//   PULSE: out_port=ASSERT_LEVEL. When the counter reaches 0 -> SETTLE, loading max(SETTLE_CYCLES,1)-1.
//   SETTLE: out_port deasserted. When the counter reaches 0 -> IDLE and set done.
//  Timing: START written in cycle N -> out_port asserted for cycles N+1 .. N+P exactly.
//   Settle occupies cycles N+P+1 .. N+P+S. done reads 1 from cycle N+P+S+1.
//   A value of 0 in PULSE_CYCLES or SETTLE_CYCLES behaves as 1.
//  out_port is deasserted (~ASSERT_LEVEL) in IDLE and SETTLE.
//  busy = (state != IDLE).
//  Reset: state=IDLE, out_port=~ASSERT_LEVEL, done=0, aborted=0, irq_en=0, irq=0, counter=0.
//   PULSE_CYCLES and SETTLE_CYCLES return to their defaults.
//   If AUTO_START=1, the first cycle after reset deasserts acts as START.
//  Boundary rules:
//   - START while busy: ignored; the counter is not reloaded.
//   - ABORT while busy: next cycle state=IDLE, out_port deasserted, aborted=1, done unchanged.
//     ABORT while IDLE has no effect.
//   - START and ABORT in the same write: ABORT wins. From IDLE this is a no-op.
//   - Writing PULSE_CYCLES or SETTLE_CYCLES while busy: the active phase is unaffected.
//     The new value applies on the next load.
//   - Clear (addr 3) in the same cycle that done is set: the set wins.
//   - reset asserted mid-sequence: immediate return to reset values. The pulse is truncated.
//   - Counters never wrap. They load, count down to 0, then stop.
// STRUCTURE
//  Shared package usb_rst_pkg: state enum, register offsets, CTRL/STAT bit indices.
//  One sub-module, usb_rst_timer (loadable CNT_W down-counter):
//   inputs load and load_val; outputs count and zero. Holds at 0.
//  The top level holds the FSM, the registers and the read mux.
// TESTING
//  1 Reset release, AUTO_START=1 -> out_port=0 for exactly 500 cycles, then 1.
//    done=1 exactly 50000 cycles later. irq stays 0 (irq_en=0).
//  2 PULSE=3, SETTLE=2, IRQ_EN|START written at cycle N -> out_port low in N+1..N+3.
//    busy through N+5. done and irq =1 at N+6.
//  3 PULSE=0, SETTLE=0, START -> a 1-cycle pulse, then a 1-cycle settle. done at N+3.
//  4 START, then ABORT 2 cycles into PULSE -> out_port high on the next cycle.
//    STAT = aborted=1, done=0, state=0. A second START restarts with a full width.
//  5 START during SETTLE ignored; START|ABORT in IDLE is a no-op.
//    Write PULSE=7 mid-PULSE: the current width is unchanged, the next run is 7 cycles.
//  6 reset asserted mid-PULSE with AUTO_START=0 -> out_port=1 and all status 0 the next cycle.
//    Also: clear (addr 3) coincident with done-set leaves done=1.

Source files
------------

// File: rtl/usb_rst_sequencer_pkg.sv
// Shared definitions for the USB reset sequencer: FSM state encoding,
// register word offsets and CTRL/STAT bit positions.
package usb_rst_pkg;

  // The encoding is software-visible through STAT[5:4].
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PULSE  = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PULSE  = 2'd1;
  localparam logic [1:0] ADDR_SETTLE = 2'd2;
  localparam logic [1:0] ADDR_COUNT  = 2'd3;

  // CTRL write bits
  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;

  // STAT read bits
  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;
  localparam int STAT_IRQ_EN   = 2;
  localparam int STAT_ABORTED  = 3;
  localparam int STAT_STATE_LO = 4;
  localparam int STAT_STATE_HI = 5;

endpackage

// File: rtl/usb_rst_sequencer_if.sv
// Avalon-MM slave bus of the USB reset sequencer (zero wait states).
interface usb_rst_sequencer_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/usb_rst_sequencer_timer.sv
// Loadable down-counter used for both the pulse and the settle phase.
// It counts down to zero and then holds there; it never wraps.
module usb_rst_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] count_r;

  // Load has priority; otherwise decrement until zero is reached.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != {CNT_W{1'b0}}) begin
      count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign zero  = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/usb_rst_sequencer.sv
// USB host-controller reset sequencer: one START write yields an exact-width
// reset pulse on out_port, a settle wait, then a sticky done flag and irq.
module usb_rst_sequencer
  import usb_rst_pkg::*;
#(
  parameter int   CNT_W          = 24,
  parameter logic ASSERT_LEVEL   = 1'b0,
  parameter int   PULSE_DEFAULT  = 500,
  parameter int   SETTLE_DEFAULT = 50000,
  parameter bit   AUTO_START     = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  usb_rst_sequencer_if.slave  bus,
  output logic                out_port,
  output logic                irq
);

  state_e           state_r, state_next_s;
  logic             done_r, done_next_s;
  logic             aborted_r, aborted_next_s;
  logic             irq_en_r, irq_en_next_s;
  logic [CNT_W-1:0] pulse_cycles_r, settle_cycles_r;
  logic             auto_pend_r;
  logic             out_port_r, irq_r;
  logic             timer_load_s, timer_zero_s;
  logic [CNT_W-1:0] timer_val_s, timer_count_s;
  logic             wr_s, ctrl_wr_s, start_s, abort_s, clear_s;
  logic [31:0]      readdata_s;

  // A programmed length of 0 behaves as 1; the counter runs length-1 .. 0.
  function automatic logic [CNT_W-1:0] phase_load(input logic [CNT_W-1:0] cycles);
    if (cycles == {CNT_W{1'b0}}) begin
      return {CNT_W{1'b0}};
    end else begin
      return cycles - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  assign wr_s      = bus.chipselect & ~bus.write_n;
  assign ctrl_wr_s = wr_s & (bus.address == ADDR_CTRL);
  assign start_s   = (ctrl_wr_s & bus.writedata[CTRL_START]) | auto_pend_r;
  assign abort_s   = ctrl_wr_s & bus.writedata[CTRL_ABORT];
  assign clear_s   = wr_s & (bus.address == ADDR_COUNT);

  usb_rst_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load_s),
    .load_val (timer_val_s),
    .count    (timer_count_s),
    .zero     (timer_zero_s)
  );

  // Next-state, counter loads and sticky status; FSM set of done wins over clear.
  always_comb begin
    state_next_s   = state_r;
    timer_load_s   = 1'b0;
    timer_val_s    = {CNT_W{1'b0}};
    done_next_s    = clear_s ? 1'b0 : done_r;
    aborted_next_s = clear_s ? 1'b0 : aborted_r;
    irq_en_next_s  = ctrl_wr_s ? bus.writedata[CTRL_IRQ_EN] : irq_en_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s && !abort_s) begin
          state_next_s   = ST_PULSE;
          timer_load_s   = 1'b1;
          timer_val_s    = phase_load(pulse_cycles_r);
          done_next_s    = 1'b0;
          aborted_next_s = 1'b0;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_PULSE: begin
        if (abort_s) begin
          state_next_s   = ST_IDLE;
          timer_load_s   = 1'b1;
          aborted_next_s = 1'b1;
        end else if (timer_zero_s) begin
          state_next_s = ST_SETTLE;
          timer_load_s = 1'b1;
          timer_val_s  = phase_load(settle_cycles_r);
        end else begin
          state_next_s = ST_PULSE;
        end
      end
      ST_SETTLE: begin
        if (abort_s) begin
          state_next_s   = ST_IDLE;
          timer_load_s   = 1'b1;
          aborted_next_s = 1'b1;
        end else if (timer_zero_s) begin
          state_next_s = ST_IDLE;
          done_next_s  = 1'b1;
        end else begin
          state_next_s = ST_SETTLE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        timer_load_s = 1'b1;
      end
    endcase
  end

  // State, status, configuration registers and registered pin/irq outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= ST_IDLE;
      done_r          <= 1'b0;
      aborted_r       <= 1'b0;
      irq_en_r        <= 1'b0;
      pulse_cycles_r  <= CNT_W'(PULSE_DEFAULT);
      settle_cycles_r <= CNT_W'(SETTLE_DEFAULT);
      auto_pend_r     <= AUTO_START;
      out_port_r      <= ~ASSERT_LEVEL;
      irq_r           <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      done_r      <= done_next_s;
      aborted_r   <= aborted_next_s;
      irq_en_r    <= irq_en_next_s;
      auto_pend_r <= 1'b0;
      out_port_r  <= (state_next_s == ST_PULSE) ? ASSERT_LEVEL : ~ASSERT_LEVEL;
      irq_r       <= done_next_s & irq_en_next_s;
      if (wr_s && (bus.address == ADDR_PULSE)) begin
        pulse_cycles_r <= bus.writedata[CNT_W-1:0];
      end else begin
        pulse_cycles_r <= pulse_cycles_r;
      end
      if (wr_s && (bus.address == ADDR_SETTLE)) begin
        settle_cycles_r <= bus.writedata[CNT_W-1:0];
      end else begin
        settle_cycles_r <= settle_cycles_r;
      end
    end
  end

  // Zero-wait-state read mux; unused bits read as zero.
  always_comb begin
    readdata_s = 32'd0;
    case (bus.address)
      ADDR_CTRL: begin
        readdata_s[STAT_BUSY]                   = (state_r != ST_IDLE);
        readdata_s[STAT_DONE]                   = done_r;
        readdata_s[STAT_IRQ_EN]                 = irq_en_r;
        readdata_s[STAT_ABORTED]                = aborted_r;
        readdata_s[STAT_STATE_HI:STAT_STATE_LO] = state_r;
      end
      ADDR_PULSE:  readdata_s[CNT_W-1:0] = pulse_cycles_r;
      ADDR_SETTLE: readdata_s[CNT_W-1:0] = settle_cycles_r;
      ADDR_COUNT:  readdata_s[CNT_W-1:0] = timer_count_s;
      default:     readdata_s = 32'd0;
    endcase
  end

  assign bus.readdata = readdata_s;
  assign out_port     = out_port_r;
  assign irq          = irq_r;

endmodule
